spike_count_classifier: RTL
===========================

SPIKE_COUNT_CLASSIFIER -- requirements
Module: spike_count_classifier

Interface
REQ-001 SHALL have parameter NUM_OUTPUTS, default 4: number of spike lines from the last network layer.
REQ-002 SHALL have parameter WINDOW, default 100: number of sampled cycles per classification window (>=1).
REQ-003 SHALL have parameter COUNT_WIDTH, default 16: width of each per-neuron spike counter.
REQ-004 SHALL have parameter IDX_WIDTH, default 2: width of the class index (2^IDX_WIDTH >= NUM_OUTPUTS).
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  system clock, all state updates on rising edge.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 start  input  1  pulse requesting a new counting window.
REQ-009 spike_in  input  NUM_OUTPUTS  spike vector from the network output layer.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 class_valid  output  1  result available.
REQ-012 class_ready  input  1  consumer accepts result.
REQ-013 class_idx  output  IDX_WIDTH  index of the winning neuron.
REQ-014 class_count  output  COUNT_WIDTH  spike count of the winning neuron.
REQ-015 no_spike  output  1  high with result when every counter is zero.

Function
REQ-016 SHALL implement FSM states IDLE, COUNT, COMPARE, HOLD.
REQ-017 IDLE: start=1 at an edge -> clear all counters and the window counter, go to COUNT; start=0 -> stay.
REQ-018 COUNT: at each of the next WINDOW edges, counter[k] SHALL increment by 1 where spike_in[k]=1; after the WINDOW-th sample, go to COMPARE.
REQ-019 Counters SHALL saturate at 2^COUNT_WIDTH-1; no wrap-around.
REQ-020 COMPARE: SHALL scan counter[0..NUM_OUTPUTS-1] sequentially, one neuron per edge, for exactly NUM_OUTPUTS edges, then go to HOLD.
REQ-021 Argmax SHALL replace the running best only on strictly greater count; ties resolve to the lowest index.
REQ-022 class_valid SHALL be high exactly while in HOLD; class_valid rises WINDOW+NUM_OUTPUTS edges after the edge that sampled start.
REQ-023 class_idx, class_count, no_spike SHALL be held stable throughout HOLD.
REQ-024 HOLD: edge with class_ready=1 -> IDLE, class_valid low after that edge; class_ready=0 -> stay indefinitely.
REQ-025 start SHALL be ignored in COUNT, COMPARE and HOLD; start and class_ready both high in HOLD -> transfer only, new window needs a fresh start in IDLE.
REQ-026 no_spike=1 with class_idx=0, class_count=0 when all counters are zero.
REQ-027 spike_in SHALL be ignored outside COUNT.

Reset
REQ-028 rst low SHALL immediately force IDLE, clear all counters, class_valid=0, busy=0, class_idx=0, class_count=0, no_spike=0, regardless of state.
REQ-029 After rst deasserts, the block SHALL wait in IDLE for start; a window interrupted by reset SHALL produce no result.

Verification (NUM_OUTPUTS=4, WINDOW=10, COUNT_WIDTH=16 unless stated)
REQ-030 Reset: assert rst low mid-COUNT -> all outputs 0 asynchronously; no class_valid after release without new start.
REQ-031 Single winner: start, spike_in=4'b0100 for all 10 samples -> class_valid at edge 14 after start, class_idx=2, class_count=10, no_spike=0.
REQ-032 Tie: neurons 1 and 3 each spike 5 times, neuron 0 spikes 4 times -> class_idx=1, class_count=5.
REQ-033 Silence: start, spike_in=0 -> class_idx=0, class_count=0, no_spike=1.
REQ-034 Backpressure: class_ready=0 for 20 cycles in HOLD, start pulsed -> outputs unchanged, busy=1; class_ready=1 -> class_valid low next edge, busy=0.
REQ-035 Saturation: COUNT_WIDTH=3, spike_in=4'b0001 for 10 samples -> class_idx=0, class_count=7.

Source files
------------

// File: rtl/spike_count_classifier.sv
// Spike-count classifier: counts output-layer spikes over a fixed window,
// then picks the neuron with the most spikes (lowest index wins ties).
module spike_count_classifier #(
  parameter int NUM_OUTPUTS = 4,
  parameter int WINDOW      = 100,
  parameter int COUNT_WIDTH = 16,
  parameter int IDX_WIDTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_OUTPUTS-1:0] spike_in,
  output logic                   busy,
  output logic                   class_valid,
  input  logic                   class_ready,
  output logic [IDX_WIDTH-1:0]   class_idx,
  output logic [COUNT_WIDTH-1:0] class_count,
  output logic                   no_spike
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0]       WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [IDX_WIDTH-1:0]   SCAN_LAST = IDX_WIDTH'(NUM_OUTPUTS - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO  = {COUNT_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COUNT   = 2'd1,
    S_COMPARE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 next_state_s;
  logic [COUNT_WIDTH-1:0] cnt_r [NUM_OUTPUTS];
  logic [WIN_W-1:0]       win_r;
  logic [IDX_WIDTH-1:0]   scan_r;
  logic [IDX_WIDTH-1:0]   best_idx_r;
  logic [COUNT_WIDTH-1:0] best_cnt_r;
  logic [COUNT_WIDTH-1:0] scan_cnt_s;
  logic                   better_s;
  logic [IDX_WIDTH-1:0]   cand_idx_s;
  logic [COUNT_WIDTH-1:0] cand_cnt_s;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) next_state_s = S_COUNT;
        else       next_state_s = S_IDLE;
      end
      S_COUNT: begin
        if (win_r == WIN_LAST) next_state_s = S_COMPARE;
        else                   next_state_s = S_COUNT;
      end
      S_COMPARE: begin
        if (scan_r == SCAN_LAST) next_state_s = S_HOLD;
        else                     next_state_s = S_COMPARE;
      end
      S_HOLD: begin
        if (class_ready) next_state_s = S_IDLE;
        else             next_state_s = S_HOLD;
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // Running argmax candidate; strict compare keeps the lowest index on ties
  always_comb begin
    scan_cnt_s = cnt_r[scan_r];
    better_s   = (scan_cnt_s > best_cnt_r);
    if (better_s) begin
      cand_idx_s = scan_r;
      cand_cnt_s = scan_cnt_s;
    end else begin
      cand_idx_s = best_idx_r;
      cand_cnt_s = best_cnt_r;
    end
  end

  // Counters, window/scan indices, running best and held results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_OUTPUTS; k++) cnt_r[k] <= CNT_ZERO;
      win_r       <= {WIN_W{1'b0}};
      scan_r      <= {IDX_WIDTH{1'b0}};
      best_idx_r  <= {IDX_WIDTH{1'b0}};
      best_cnt_r  <= CNT_ZERO;
      class_idx   <= {IDX_WIDTH{1'b0}};
      class_count <= CNT_ZERO;
      no_spike    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            for (int k = 0; k < NUM_OUTPUTS; k++) cnt_r[k] <= CNT_ZERO;
            win_r      <= {WIN_W{1'b0}};
            scan_r     <= {IDX_WIDTH{1'b0}};
            best_idx_r <= {IDX_WIDTH{1'b0}};
            best_cnt_r <= CNT_ZERO;
          end
        end
        S_COUNT: begin
          for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (spike_in[k] && (cnt_r[k] != CNT_MAX)) begin
              cnt_r[k] <= cnt_r[k] + COUNT_WIDTH'(1);
            end
          end
          win_r <= win_r + WIN_W'(1);
        end
        S_COMPARE: begin
          best_idx_r <= cand_idx_s;
          best_cnt_r <= cand_cnt_s;
          scan_r     <= scan_r + IDX_WIDTH'(1);
          if (scan_r == SCAN_LAST) begin
            class_idx   <= cand_idx_s;
            class_count <= cand_cnt_s;
            no_spike    <= (cand_cnt_s == CNT_ZERO);
          end
        end
        S_HOLD: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Status flags registered from the next state so they track the FSM exactly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy        <= 1'b0;
      class_valid <= 1'b0;
    end else begin
      busy        <= (next_state_s != S_IDLE);
      class_valid <= (next_state_s == S_HOLD);
    end
  end

endmodule
